uart_tx: RTL and testbench
==========================

# uart_tx

UART transmit serializer that sits directly downstream of the transmit `fifo` and drains it one frame at a time. When the FIFO is not empty, it pops one word using the FIFO's same-cycle read. It then shifts the word out on `o_tx` as a configurable asynchronous frame: start bit, data LSB-first, optional parity, and 1 or 2 stop bits. Bit timing comes from a runtime clock divider, and back-to-back frames are sent with no idle gap.

## Interface
Parameters:
- `SIZE_DATA`, default 8: data bits per frame; also the FIFO word width.
- `SIZE_DIV`, default 16: width of the baud divider.

Ports:
- `i_clk`, in, 1: the single clock for the block.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_en`, in, 1: transmit enable. It gates only the start of new frames.
- `i_baud_div`, in, `SIZE_DIV`: bit period is `i_baud_div`+1 clock cycles.
- `i_parity_en`, in, 1: when 1, a parity bit is appended after the data bits.
- `i_parity_odd`, in, 1: 1 selects odd parity, 0 selects even parity.
- `i_stop2`, in, 1: 1 selects two stop bits, 0 selects one.
- `i_fifo_empty`, in, 1: driven by FIFO `o_fifo_empty`.
- `i_fifo_data`, in, `SIZE_DATA`: driven by FIFO `o_data`. It is valid only in a cycle where `o_fifo_rd`=1.
- `o_fifo_rd`, out, 1: drives FIFO `i_en_rd`. Each high cycle pops one word.
- `o_tx`, out, 1: serial line output, registered. The idle level is high.
- `o_busy`, out, 1: high while a frame is in progress.
- `o_done`, out, 1: one-cycle pulse in the final cycle of each frame.

## Operation
- The state machine has five states: IDLE, START, DATA, PARITY, STOP.
- **Pop condition.** `o_fifo_rd` = `i_en` & ~`i_fifo_empty` & (state==IDLE | final cycle of the last stop bit). It is combinational and is forced to 0 while `i_rst_n`=0.
- **Launch cycle.** In any cycle where `o_fifo_rd`=1, the block:
  - captures `i_fifo_data` into the shift register;
  - latches `i_baud_div`, `i_parity_en`, `i_parity_odd` and `i_stop2` into shadow registers;
  - computes parity: even = XOR of the data bits, odd = inverted XOR;
  - moves to START.
- Configuration inputs that change mid-frame have no effect until the next launch.
- **Baud counter.** Loads the shadow divider at each bit start and counts down to 0. A bit ends in the cycle where the counter is 0.
- **Bit counter.** Counts data bits 0..`SIZE_DATA`-1 and stop bits 0..1.
- **Transitions:**
  - START → DATA.
  - DATA (after the last data bit) → PARITY if parity is enabled, otherwise → STOP.
  - PARITY → STOP.
  - STOP (after the last stop bit) → START if `o_fifo_rd`=1, otherwise → IDLE.
- **`o_tx` per state:**
  - IDLE: 1.
  - START: 0.
  - DATA: shift-register bit 0; the register shifts right at each data-bit end.
  - PARITY: the latched parity bit.
  - STOP: 1.
- `o_busy` = (state != IDLE).
- `o_done` = 1 in the final cycle of the last stop bit. It is decoded from registered state and counters only, with no dependence on any input.
- When `i_en` falls mid-frame, the current frame completes and no further pop occurs.
- The upstream FIFO guarantees no pop is issued while it is empty.

## Timing
- **Reset values:** `o_tx`=1, `o_busy`=0, `o_done`=0, `o_fifo_rd`=0, state=IDLE, all counters 0.
- **Reset mid-frame:** `o_tx` returns to 1 asynchronously and the frame is abandoned. The already-popped word is lost.
- **Frame start latency:** a pop at cycle T drives `o_tx` low from cycle T+1.
- **Bit timing:** each bit lasts D = `i_baud_div`+1 cycles. `i_baud_div`=0 is legal (1 cycle per bit).
- **Frame length:** (1 + `SIZE_DATA` + P + S)·D cycles, where P = 1 if parity is enabled (else 0) and S = 1 or 2 stop bits.
  - `o_busy` is high for exactly this many cycles per frame.
  - `o_done` fires in the last of these cycles.
- **Back-to-back frames:** the pop for the next frame coincides with `o_done`. The next start bit begins on the following cycle, so there is no idle gap and `o_busy` stays high.
- **Divider width:** the maximum divider is 2^`SIZE_DIV`-1, and the counter must not overflow.

## Test plan
1. **Reset.** Hold `i_rst_n`=0 with the FIFO non-empty → `o_tx`=1, `o_busy`=0, `o_fifo_rd`=0, `o_done`=0.
2. **Single 8N1 frame.** 8N1 with `i_baud_div`=3; FIFO holds 0xA5.
   - `o_fifo_rd` pulses for 1 cycle.
   - `o_tx` sends 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles.
   - `o_busy` stays high for 40 cycles and `o_done` pulses at cycle 40.
   - The FIFO is empty afterwards.
3. **Parity and two stop bits.** Data 0x07 with `i_baud_div`=0.
   - Even parity: the parity bit is 1.
   - Odd parity: the parity bit is 0.
   - With `i_stop2`=1, the frame is 12 cycles long with the last 2 cycles high.
4. **Back-to-back frames.** FIFO holds 0x55 then 0xAA; `i_baud_div`=3.
   - The second pop coincides with the first `o_done`.
   - `o_busy` stays high for 80 cycles, and the second start bit follows the stop bit with no gap.
5. **Enable gating.** `i_en`=0 with the FIFO non-empty → no pop. Dropping `i_en` mid-DATA → the frame completes, then IDLE with no pop.
6. **Mid-frame events.**
   - Assert reset during DATA → `o_tx`=1 immediately; after release, the next frame is correct.
   - Change `i_baud_div` mid-frame → the current frame keeps its latched timing.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit serializer draining an upstream FIFO.
// Frame: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx #(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_DIV  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [SIZE_DIV-1:0]  i_baud_div,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_stop2,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_fifo_rd,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(SIZE_DATA - 1);
  localparam logic [CW-1:0] ONE_B    = CW'(1);
  localparam logic [CW-1:0] ZERO_B   = '0;

  localparam logic [SIZE_DIV-1:0] ONE_D = SIZE_DIV'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [SIZE_DIV-1:0]  baud_cnt;
  logic [SIZE_DIV-1:0]  div_q;
  logic [CW-1:0]        bit_cnt;
  logic [SIZE_DATA-1:0] shift;
  logic [SIZE_DATA-1:0] shift_nx;
  logic                 par_en_q;
  logic                 stop2_q;
  logic                 par_q;
  logic                 tx_q;

  logic                 bit_end;
  logic                 last_stop;
  logic                 launch;

  // Bit boundaries and the frame-end decode from registered state only.
  always_comb begin
    bit_end   = (state != S_IDLE) && (baud_cnt == '0);
    last_stop = (state == S_STOP) && bit_end &&
                (bit_cnt == (stop2_q ? ONE_B : ZERO_B));
    launch    = i_en && !i_fifo_empty &&
                ((state == S_IDLE) || last_stop);
    shift_nx  = shift >> 1;
  end

  assign o_fifo_rd = launch && i_rst_n;
  assign o_done    = last_stop;
  assign o_busy    = (state != S_IDLE);
  assign o_tx      = tx_q;

  // Frame sequencer: launch, per-bit countdown, state advance, line drive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      div_q    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else if (launch) begin
      shift    <= i_fifo_data;
      div_q    <= i_baud_div;
      par_en_q <= i_parity_en;
      stop2_q  <= i_stop2;
      par_q    <= (^i_fifo_data) ^ i_parity_odd;
      baud_cnt <= i_baud_div;
      bit_cnt  <= '0;
      state    <= S_START;
      tx_q     <= 1'b0;
    end else if (state == S_IDLE) begin
      tx_q <= 1'b1;
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt - ONE_D;
    end else begin
      baud_cnt <= div_q;
      unique case (1'b1)
        (state == S_START): begin
          state   <= S_DATA;
          bit_cnt <= '0;
          tx_q    <= shift[0];
        end
        (state == S_DATA): begin
          shift <= shift_nx;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (par_en_q) begin
              state <= S_PARITY;
              tx_q  <= par_q;
            end else begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + ONE_B;
            tx_q    <= shift_nx[0];
          end
        end
        (state == S_PARITY): begin
          state   <= S_STOP;
          bit_cnt <= '0;
          tx_q    <= 1'b1;
        end
        (state == S_STOP): begin
          tx_q <= 1'b1;
          if (last_stop) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + ONE_B;
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a small FIFO model.
// Captures each frame cycle by cycle and checks it.
module tb_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic        par;
  logic        odd;
  logic        stop2;
  logic        empty;
  logic [7:0]  fdata;
  logic        rd;
  logic        tx;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:15];
  int          wp;
  int          rp;

  int total;
  int bad;

  logic tx_s   [0:127];
  logic busy_s [0:127];
  logic done_s [0:127];
  logic rd_s   [0:127];

  uart_tx #(.SIZE_DATA(8), .SIZE_DIV(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_baud_div   (div),
    .i_parity_en  (par),
    .i_parity_odd (odd),
    .i_stop2      (stop2),
    .i_fifo_empty (empty),
    .i_fifo_data  (fdata),
    .o_fifo_rd    (rd),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = (wp == rp);
  assign fdata = mem[rp[3:0]];

  always @(posedge clk) begin
    if (rd) rp <= rp + 1;
  end

  task automatic push(input logic [7:0] d);
    mem[wp[3:0]] = d;
    wp = wp + 1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pop(input string tag);
    int got;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (rd === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, got, 1);
  endtask

  task automatic capture(input int n,
                         input int en_off_at,
                         input int div_at,
                         input logic [15:0] nd);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tx_s[k]   = tx;
      busy_s[k] = busy;
      done_s[k] = done;
      rd_s[k]   = rd;
      if (k == en_off_at) en = 1'b0;
      if (k == div_at) div = nd;
    end
  endtask

  task automatic check_frame(input string tag,
                             input int base,
                             input int nbits,
                             input int d,
                             input logic [31:0] exp);
    logic [31:0] f;
    logic [31:0] l;
    f = '0;
    l = '0;
    for (int b = 0; b < nbits; b++) begin
      f[b] = tx_s[base + b*d];
      l[b] = tx_s[base + b*d + d - 1];
    end
    chk({tag, "_first"}, f, exp);
    chk({tag, "_last"}, l, exp);
  endtask

  function automatic int cnt_busy(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) c += int'(busy_s[k]);
    return c;
  endfunction

  function automatic int cnt_done(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) c += int'(done_s[k]);
    return c;
  endfunction

  function automatic int cnt_rd(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) c += int'(rd_s[k]);
    return c;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    wp    = 0;
    rp    = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    div   = 16'd3;
    par   = 1'b0;
    odd   = 1'b0;
    stop2 = 1'b0;
    push(8'hA5);

    // reset with a non-empty FIFO and enable high
    repeat (2) @(negedge clk);
    en = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;

    // enable low: no pop
    repeat (3) @(negedge clk);
    chk("en_off_rd", 32'(rd), 0);
    chk("en_off_level", wp - rp, 1);

    // single 8N1 frame, D=4
    en = 1'b1;
    wait_pop("f1_pop");
    capture(45, 0, 0, 16'd0);
    check_frame("f1", 1, 10, 4, {22'd0, 1'b1, 8'hA5, 1'b0});
    chk("f1_busy", cnt_busy(1, 45), 40);
    chk("f1_done40", 32'(done_s[40]), 1);
    chk("f1_ndone", cnt_done(1, 45), 1);
    chk("f1_rd", cnt_rd(1, 45), 0);
    chk("f1_idle_tx", 32'(tx_s[41]), 1);
    chk("f1_empty", 32'(empty), 1);

    // even parity, D=1
    div = 16'd0;
    par = 1'b1;
    odd = 1'b0;
    push(8'h07);
    wait_pop("pe_pop");
    capture(14, 0, 0, 16'd0);
    check_frame("pe", 1, 11, 1, {21'd0, 1'b1, 1'b1, 8'h07, 1'b0});
    chk("pe_busy", cnt_busy(1, 14), 11);
    chk("pe_done", 32'(done_s[11]), 1);

    // odd parity
    odd = 1'b1;
    push(8'h07);
    wait_pop("po_pop");
    capture(14, 0, 0, 16'd0);
    check_frame("po", 1, 11, 1, {21'd0, 1'b1, 1'b0, 8'h07, 1'b0});
    chk("po_busy", cnt_busy(1, 14), 11);

    // even parity with two stop bits
    odd = 1'b0;
    stop2 = 1'b1;
    push(8'h07);
    wait_pop("s2_pop");
    capture(15, 0, 0, 16'd0);
    check_frame("s2", 1, 12, 1, {20'd0, 2'b11, 1'b1, 8'h07, 1'b0});
    chk("s2_busy", cnt_busy(1, 15), 12);
    chk("s2_done", 32'(done_s[12]), 1);
    chk("s2_ndone", cnt_done(1, 15), 1);

    // back-to-back frames
    par = 1'b0;
    stop2 = 1'b0;
    div = 16'd3;
    push(8'h55);
    push(8'hAA);
    wait_pop("bb_pop");
    capture(85, 0, 0, 16'd0);
    check_frame("bb1", 1, 10, 4, {22'd0, 1'b1, 8'h55, 1'b0});
    check_frame("bb2", 41, 10, 4, {22'd0, 1'b1, 8'hAA, 1'b0});
    chk("bb_rd40", 32'(rd_s[40]), 1);
    chk("bb_done40", 32'(done_s[40]), 1);
    chk("bb_nrd", cnt_rd(1, 85), 1);
    chk("bb_busy", cnt_busy(1, 80), 80);
    chk("bb_idle", 32'(busy_s[81]), 0);
    chk("bb_ndone", cnt_done(1, 85), 2);
    chk("bb_start2", 32'(tx_s[41]), 0);

    // enable dropped mid-DATA
    push(8'h3C);
    push(8'h81);
    wait_pop("ed_pop");
    capture(45, 15, 0, 16'd0);
    check_frame("ed", 1, 10, 4, {22'd0, 1'b1, 8'h3C, 1'b0});
    chk("ed_done", 32'(done_s[40]), 1);
    chk("ed_rd", cnt_rd(1, 45), 0);
    chk("ed_idle", 32'(busy_s[41]), 0);
    chk("ed_level", wp - rp, 1);

    // reset during DATA drops the line high at once
    en = 1'b1;
    wait_pop("mr_pop");
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_tx", 32'(tx), 1);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    push(8'h5A);
    #1;
    chk("mr_rd", 32'(rd), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_pop("ar_pop");
    capture(45, 0, 0, 16'd0);
    check_frame("ar", 1, 10, 4, {22'd0, 1'b1, 8'h5A, 1'b0});
    chk("ar_busy", cnt_busy(1, 45), 40);

    // divider changed mid-frame keeps latched timing
    div = 16'd1;
    push(8'hC3);
    wait_pop("dv_pop");
    capture(24, 0, 5, 16'd7);
    check_frame("dv", 1, 10, 2, {22'd0, 1'b1, 8'hC3, 1'b0});
    chk("dv_busy", cnt_busy(1, 24), 20);
    chk("dv_done", 32'(done_s[20]), 1);
    chk("dv_empty", 32'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
